// File: rtl/ram_write_buffer_if.sv
// Bus bundle for the posted-write buffer: the CPU data-memory port on one
// side and the data-RAM port on the other. The buffer is the slave; whoever
// plays CPU + RAM (the surrounding core, or a bench) is the master.
interface ram_write_buffer_if;
    // CPU store side
    logic        cpu_write_enable;
    logic [31:0] cpu_write_address;
    logic [3:0]  cpu_write_select;
    logic [31:0] cpu_write_data;
    logic        cpu_write_stall;
    // CPU load side
    logic        cpu_read_enable;
    logic [31:0] cpu_read_address;
    logic [31:0] cpu_read_data;
    // RAM write side
    logic        ram_write_enable;
    logic [31:0] ram_write_address;
    logic [3:0]  ram_write_select;
    logic [31:0] ram_write_data;
    logic        ram_write_ready;
    // RAM read side
    logic        ram_read_enable;
    logic [31:0] ram_read_address;
    logic [31:0] ram_read_data;
    // status
    logic        buffer_empty;

    modport slave (
        input  cpu_write_enable, cpu_write_address, cpu_write_select, cpu_write_data,
        output cpu_write_stall,
        input  cpu_read_enable, cpu_read_address,
        output cpu_read_data,
        output ram_write_enable, ram_write_address, ram_write_select, ram_write_data,
        input  ram_write_ready,
        output ram_read_enable, ram_read_address,
        input  ram_read_data,
        output buffer_empty
    );

    modport master (
        output cpu_write_enable, cpu_write_address, cpu_write_select, cpu_write_data,
        input  cpu_write_stall,
        output cpu_read_enable, cpu_read_address,
        input  cpu_read_data,
        input  ram_write_enable, ram_write_address, ram_write_select, ram_write_data,
        output ram_write_ready,
        input  ram_read_enable, ram_read_address,
        output ram_read_data,
        input  buffer_empty
    );
endinterface

// File: rtl/ram_write_buffer.sv
// Posted-write FIFO between the CPU data port and the data RAM. Stores are
// accepted in one cycle and drained whenever the RAM is ready; loads pass
// straight through with byte-wise forwarding from still-pending stores.
module ram_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    ram_write_buffer_if.slave  bus
);

    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [PTR_WIDTH:0]   count_q, count_d;

    logic [29:0] addr_q [DEPTH];
    logic [3:0]  sel_q  [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic full;
    logic enq;
    logic deq;

    // Byte offset of a store address is meaningless to a word-wide entry.
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.cpu_write_address[1:0];

    // Full blocks acceptance even when the head drains this same cycle, so
    // the stall never depends on ram_write_ready.
    assign full = (count_q == (PTR_WIDTH+1)'(DEPTH));
    assign enq  = bus.cpu_write_enable && !full;
    assign deq  = (count_q != '0) && bus.ram_write_ready;

    assign bus.cpu_write_stall = bus.cpu_write_enable && full;
    assign bus.buffer_empty    = (count_q == '0);

    // Head entry is presented to the RAM as-is; storage is cleared on reset
    // so the write bus reads zero out of reset.
    assign bus.ram_write_enable  = (count_q != '0);
    assign bus.ram_write_address = {addr_q[head_q], 2'b00};
    assign bus.ram_write_select  = sel_q[head_q];
    assign bus.ram_write_data    = data_q[head_q];

    assign bus.ram_read_enable  = bus.cpu_read_enable;
    assign bus.ram_read_address = bus.cpu_read_address;

    // Pointer and occupancy next-state; both pointers wrap modulo DEPTH.
    always_comb begin
        head_d  = head_q + (deq ? PTR_WIDTH'(1) : PTR_WIDTH'(0));
        tail_d  = tail_q + (enq ? PTR_WIDTH'(1) : PTR_WIDTH'(0));
        count_d = count_q + (enq ? (PTR_WIDTH+1)'(1) : '0) - (deq ? (PTR_WIDTH+1)'(1) : '0);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: an accepted store lands at the tail slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                sel_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (enq) begin
            addr_q[tail_q] <= bus.cpu_write_address[31:2];
            sel_q[tail_q]  <= bus.cpu_write_select;
            data_q[tail_q] <= bus.cpu_write_data;
        end
    end

    logic [PTR_WIDTH-1:0] fwd_idx;
    logic [31:0]          fwd_data;

    // Load forwarding: walk valid entries oldest to youngest so the youngest
    // matching byte wins; the store on the CPU port this cycle is not visible.
    always_comb begin
        fwd_idx  = '0;
        fwd_data = bus.ram_read_data;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_WIDTH'(i);
            if (((PTR_WIDTH+1)'(i) < count_q) &&
                (addr_q[fwd_idx] == bus.cpu_read_address[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_q[fwd_idx][b])
                        fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                end
            end
        end
        bus.cpu_read_data = bus.cpu_read_enable ? fwd_data : 32'h0;
    end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Self-checking bench for ram_write_buffer: directed scenarios plus a
// randomized run against a queue-based reference of the posted-write buffer.
module tb_ram_write_buffer;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ram_write_buffer_if bus ();

    ram_write_buffer #(.DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [29:0] wa;
        logic [3:0]  sel;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];            // reference: pending stores, oldest first
    ent_t        obs[$];           // writes the DUT actually issued to RAM
    logic [31:0] mem [logic [29:0]];
    int errs   = 0;
    int checks = 0;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    // What a load should see: RAM word overlaid by pending stores in age order.
    function automatic logic [31:0] exp_read(input bit en, input logic [31:0] a);
        logic [31:0] r;
        if (!en) return 32'h0;
        r = memrd(a);
        foreach (mq[i])
            if (mq[i].wa == a[31:2])
                for (int b = 0; b < 4; b++)
                    if (mq[i].sel[b]) r[8*b +: 8] = mq[i].d[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input bit we, input logic [31:0] wa, input logic [3:0] ws,
                         input logic [31:0] wd, input bit re, input logic [31:0] ra,
                         input bit rdy);
        bus.cpu_write_enable  = we;
        bus.cpu_write_address = wa;
        bus.cpu_write_select  = ws;
        bus.cpu_write_data    = wd;
        bus.cpu_read_enable   = re;
        bus.cpu_read_address  = ra;
        bus.ram_write_ready   = rdy;
        bus.ram_read_data     = memrd(ra);
        #1;
    endtask

    // One clock: RAM model absorbs the DUT's write, reference applies the rules.
    task automatic tick();
        bit   enq, deq;
        ent_t e;
        enq = bus.cpu_write_enable && (mq.size() < DEPTH);
        deq = (mq.size() != 0) && bus.ram_write_ready;
        e   = '{bus.cpu_write_address[31:2], bus.cpu_write_select, bus.cpu_write_data};
        if (bus.ram_write_enable === 1'b1 && bus.ram_write_ready && reset) begin
            logic [31:0] w;
            obs.push_back('{bus.ram_write_address[31:2], bus.ram_write_select, bus.ram_write_data});
            w = memrd(bus.ram_write_address);
            for (int b = 0; b < 4; b++)
                if (bus.ram_write_select[b]) w[8*b +: 8] = bus.ram_write_data[8*b +: 8];
            mem[bus.ram_write_address[31:2]] = w;
        end
        @(posedge clock);
        if (!reset) mq.delete();
        else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back(e);
        end
        #1;
        bus.ram_read_data = memrd(bus.cpu_read_address);
        #1;
    endtask

    task automatic drain(input string tag);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 20 && mq.size() != 0; k++) tick();
        checks++;
        if (bus.buffer_empty !== 1'b1 || mq.size() != 0) begin
            errs++;
            $display("FAIL %s_drain: buffer_empty=%b model_pending=%0d, want 1/0", tag, bus.buffer_empty, mq.size());
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.ram_write_enable !== 1'b0) begin errs++; $display("FAIL reset_wen: got %b want 0", bus.ram_write_enable); end
        checks++; if (bus.buffer_empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b want 1", bus.buffer_empty); end
        checks++; if (bus.cpu_write_stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", bus.cpu_write_stall); end
        checks++; if ({bus.ram_write_address, bus.ram_write_select, bus.ram_write_data} !== 68'h0) begin
            errs++; $display("FAIL reset_wbus: got %h/%h/%h want 0", bus.ram_write_address, bus.ram_write_select, bus.ram_write_data); end
        drive(1, 32'h10, 4'hF, 32'h1, 0, 0, 0);
        checks++; if (bus.cpu_write_stall !== 1'b0) begin errs++; $display("FAIL reset_stall_we: got %b want 0", bus.cpu_write_stall); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic_drain();
        drive(1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 1);
        checks++; if (bus.cpu_write_stall !== 1'b0) begin errs++; $display("FAIL basic_stall: got %b want 0", bus.cpu_write_stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus.ram_write_enable !== 1'b1) begin errs++; $display("FAIL basic_wen: got %b want 1", bus.ram_write_enable); end
        checks++; if (bus.ram_write_address !== 32'h100) begin errs++; $display("FAIL basic_addr: got %h want 00000100", bus.ram_write_address); end
        checks++; if (bus.ram_write_data !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_data: got %h want deadbeef", bus.ram_write_data); end
        checks++; if (bus.ram_write_select !== 4'hF) begin errs++; $display("FAIL basic_sel: got %h want f", bus.ram_write_select); end
        checks++; if (bus.buffer_empty !== 1'b0) begin errs++; $display("FAIL basic_busy: got %b want 0", bus.buffer_empty); end
        tick();
        checks++; if (bus.buffer_empty !== 1'b1) begin errs++; $display("FAIL basic_empty: got %b want 1", bus.buffer_empty); end
        checks++; if (bus.ram_write_enable !== 1'b0) begin errs++; $display("FAIL basic_wen_off: got %b want 0", bus.ram_write_enable); end
    endtask

    task automatic test_fill_stall();
        ent_t st[5];
        obs.delete();
        for (int k = 0; k < 5; k++)
            st[k] = '{30'h100 + 30'(k), 4'hF, $urandom};
        for (int k = 0; k < 4; k++) begin
            drive(1, {st[k].wa, 2'b00}, st[k].sel, st[k].d, 0, 0, 0);
            checks++; if (bus.cpu_write_stall !== 1'b0) begin errs++; $display("FAIL fill_stall%0d: got %b want 0", k, bus.cpu_write_stall); end
            tick();
        end
        drive(1, {st[4].wa, 2'b00}, st[4].sel, st[4].d, 0, 0, 0);
        checks++; if (bus.cpu_write_stall !== 1'b1) begin errs++; $display("FAIL fill_full: got %b want 1", bus.cpu_write_stall); end
        tick();
        checks++; if (bus.cpu_write_stall !== 1'b1) begin errs++; $display("FAIL fill_hold: got %b want 1", bus.cpu_write_stall); end
        drive(1, {st[4].wa, 2'b00}, st[4].sel, st[4].d, 0, 0, 1);
        checks++; if (bus.cpu_write_stall !== 1'b1) begin errs++; $display("FAIL fill_full_deq: got %b want 1", bus.cpu_write_stall); end
        tick();
        checks++; if (bus.cpu_write_stall !== 1'b0) begin errs++; $display("FAIL fill_release: got %b want 0", bus.cpu_write_stall); end
        tick();
        drain("fill");
        checks++;
        if (obs.size() != 5) begin errs++; $display("FAIL fill_count: got %0d writes want 5", obs.size()); end
        else for (int k = 0; k < 5; k++)
            if (obs[k] != st[k]) begin
                errs++; $display("FAIL fill_order%0d: got %h/%h/%h want %h/%h/%h", k,
                    obs[k].wa, obs[k].sel, obs[k].d, st[k].wa, st[k].sel, st[k].d);
            end
    endtask

    task automatic test_forward_merge();
        mem[32'h200 >> 2] = 32'hAABBCCDD;
        drive(1, 32'h200, 4'b0011, 32'h0000_1122, 0, 0, 0);
        tick();
        drive(1, 32'h200, 4'b0010, 32'h0000_3300, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h200, 0);
        checks++; if (bus.cpu_read_data !== 32'hAABB3322) begin errs++; $display("FAIL fwd_merge: got %h want aabb3322", bus.cpu_read_data); end
        checks++; if (bus.ram_read_enable !== 1'b1 || bus.ram_read_address !== 32'h200) begin
            errs++; $display("FAIL fwd_pass: got %b/%h want 1/00000200", bus.ram_read_enable, bus.ram_read_address); end
        drive(0, 0, 0, 0, 0, 32'h200, 0);
        checks++; if (bus.cpu_read_data !== 32'h0) begin errs++; $display("FAIL fwd_rd_off: got %h want 0", bus.cpu_read_data); end
        drain("fwd");
        drive(0, 0, 0, 0, 1, 32'h200, 0);
        checks++; if (bus.cpu_read_data !== 32'hAABB3322) begin errs++; $display("FAIL fwd_after_drain: got %h want aabb3322", bus.cpu_read_data); end
    endtask

    task automatic test_no_same_cycle();
        mem[32'h300 >> 2] = 32'h55667788;
        drive(1, 32'h300, 4'hF, 32'h12345678, 1, 32'h300, 0);
        checks++; if (bus.cpu_read_data !== 32'h55667788) begin errs++; $display("FAIL same_cycle: got %h want 55667788", bus.cpu_read_data); end
        tick();
        drive(0, 0, 0, 0, 1, 32'h300, 0);
        checks++; if (bus.cpu_read_data !== 32'h12345678) begin errs++; $display("FAIL next_cycle_fwd: got %h want 12345678", bus.cpu_read_data); end
        drain("nsc");
    endtask

    task automatic test_wrap();
        ent_t st[12];
        int   i = 0;
        obs.delete();
        for (int k = 0; k < 12; k++) st[k] = '{30'h180 + 30'(k), 4'($urandom), $urandom};
        for (int cyc = 0; cyc < 200 && i < 12; cyc++) begin
            drive(1, {st[i].wa, 2'b01}, st[i].sel, st[i].d, 0, 0, cyc[0] == 1'b0);
            checks++;
            if (bus.cpu_write_stall !== (mq.size() == DEPTH)) begin
                errs++; $display("FAIL wrap_stall c%0d: got %b want %b", cyc, bus.cpu_write_stall, mq.size() == DEPTH);
            end
            if (mq.size() != 0) begin
                checks++;
                if (bus.ram_write_enable !== 1'b1 || bus.ram_write_address[31:2] !== mq[0].wa || bus.ram_write_data !== mq[0].d) begin
                    errs++; $display("FAIL wrap_head c%0d: got %b/%h/%h want 1/%h/%h", cyc, bus.ram_write_enable,
                        bus.ram_write_address[31:2], bus.ram_write_data, mq[0].wa, mq[0].d);
                end
            end
            if (bus.cpu_write_stall === 1'b0) i++;
            tick();
        end
        checks++; if (i != 12) begin errs++; $display("FAIL wrap_accept: got %0d accepted want 12", i); end
        drain("wrap");
        checks++;
        if (obs.size() != 12) begin errs++; $display("FAIL wrap_count: got %0d writes want 12", obs.size()); end
        else for (int k = 0; k < 12; k++)
            if (obs[k] != st[k]) begin
                errs++; $display("FAIL wrap_order%0d: got %h/%h/%h want %h/%h/%h", k,
                    obs[k].wa, obs[k].sel, obs[k].d, st[k].wa, st[k].sel, st[k].d);
            end
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h700 + 32'(4*k), 4'hF, $urandom, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.ram_write_enable !== 1'b1) begin errs++; $display("FAIL mid_pending: got %b want 1", bus.ram_write_enable); end
        obs.delete();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.ram_write_enable !== 1'b0) begin errs++; $display("FAIL mid_wen: got %b want 0", bus.ram_write_enable); end
        checks++; if (bus.buffer_empty !== 1'b1) begin errs++; $display("FAIL mid_empty: got %b want 1", bus.buffer_empty); end
        drive(0, 0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        checks++; if (obs.size() != 0) begin errs++; $display("FAIL mid_no_write: got %0d writes want 0", obs.size()); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 1), 32'h500 + 32'($urandom_range(0, 15)), 4'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, 32'h500 + 32'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
            checks++;
            if (bus.cpu_write_stall !== (bus.cpu_write_enable && mq.size() == DEPTH) ||
                bus.buffer_empty !== (mq.size() == 0) || bus.ram_write_enable !== (mq.size() != 0)) begin
                errs++; $display("FAIL rnd_status c%0d: got stall=%b empty=%b wen=%b, pending=%0d", cyc,
                    bus.cpu_write_stall, bus.buffer_empty, bus.ram_write_enable, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (bus.ram_write_address !== {mq[0].wa, 2'b00} || bus.ram_write_select !== mq[0].sel || bus.ram_write_data !== mq[0].d) begin
                    errs++; $display("FAIL rnd_head c%0d: got %h/%h/%h want %h/%h/%h", cyc, bus.ram_write_address,
                        bus.ram_write_select, bus.ram_write_data, {mq[0].wa, 2'b00}, mq[0].sel, mq[0].d);
                end
            end
            checks++;
            if (bus.cpu_read_data !== exp_read(bus.cpu_read_enable, bus.cpu_read_address)) begin
                errs++; $display("FAIL rnd_read c%0d: got %h want %h", cyc, bus.cpu_read_data,
                    exp_read(bus.cpu_read_enable, bus.cpu_read_address));
            end
            tick();
        end
        drain("rnd");
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_fill_stall();
        test_forward_merge();
        test_no_same_cycle();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
